// File: rtl/thread_pc.sv
// Per-thread fetch PC tracker: each hardware thread runs its own RUN/MISS/DRAIN
// refill FSM and holds its fetch PC, saved exception PC and privilege mode.
module thread_pc #(
  parameter int unsigned n_threads  = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_1000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_2000,
  localparam int unsigned TW = (n_threads > 1) ? $clog2(n_threads) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fetch_valid,
  input  logic [TW-1:0]                 fetch_thread,
  input  logic                          fetch_itlb_miss,
  input  logic                          fetch_icache_miss,
  input  logic                          fill_en,
  input  logic [TW-1:0]                 fill_thread,
  input  logic                          br_en,
  input  logic [TW-1:0]                 br_thread,
  input  logic [31:0]                   br_target,
  input  logic                          exc_en,
  input  logic [TW-1:0]                 exc_thread,
  input  logic [31:0]                   exc_pc,
  input  logic                          iret_en,
  input  logic [TW-1:0]                 iret_thread,
  output logic [n_threads-1:0][31:0]    pc,
  output logic [n_threads-1:0][31:0]    epc,
  output logic [n_threads-1:0]          mode,
  output logic [n_threads-1:0]          stalled
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MISS  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                       state_q [n_threads];
  state_e                       state_d [n_threads];
  logic [n_threads-1:0][31:0]   pc_q, pc_d;
  logic [n_threads-1:0][31:0]   epc_q, epc_d;
  logic [n_threads-1:0]         mode_q, mode_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned t = 0; t < n_threads; t++) begin
        state_q[t] <= RUN;
        pc_q[t]    <= RESET_PC;
        epc_q[t]   <= '0;
      end
      mode_q <= '1;
    end else begin
      for (int unsigned t = 0; t < n_threads; t++) begin
        state_q[t] <= state_d[t];
      end
      pc_q   <= pc_d;
      epc_q  <= epc_d;
      mode_q <= mode_d;
    end
  end

  always_comb begin
    pc_d   = pc_q;
    epc_d  = epc_q;
    mode_d = mode_q;
    for (int unsigned t = 0; t < n_threads; t++) begin
      logic hit_t, fetch_t, fill_t, br_t, exc_t, iret_t, redir_t;
      state_d[t] = state_q[t];
      fetch_t = fetch_valid && (fetch_thread == TW'(t));
      fill_t  = fill_en     && (fill_thread  == TW'(t));
      br_t    = br_en       && (br_thread    == TW'(t));
      exc_t   = exc_en      && (exc_thread   == TW'(t));
      iret_t  = iret_en     && (iret_thread  == TW'(t));
      redir_t = exc_t || iret_t || br_t;
      hit_t   = fetch_t && (state_q[t] == RUN) && !fetch_itlb_miss && !fetch_icache_miss;

      if (exc_t) begin
        pc_d[t]   = EXC_VECTOR;
        epc_d[t]  = exc_pc;
        mode_d[t] = 1'b1;
      end else if (iret_t) begin
        pc_d[t]   = epc_q[t];
        mode_d[t] = 1'b0;
      end else if (br_t) begin
        pc_d[t]   = br_target & ~32'h3;
      end else if (hit_t) begin
        pc_d[t]   = pc_q[t] + 32'd4;
      end

      // A completing refill always returns to RUN, even alongside a redirect;
      // the redirect PC (if any) is already in pc_d.
      unique case (state_q[t])
        RUN: begin
          if (!redir_t && fetch_t && fetch_icache_miss && !fetch_itlb_miss)
            state_d[t] = MISS;
        end
        MISS: begin
          if (fill_t)       state_d[t] = RUN;
          else if (redir_t) state_d[t] = DRAIN;
        end
        DRAIN: begin
          if (fill_t)       state_d[t] = RUN;
        end
        default: state_d[t] = RUN;
      endcase
    end
  end

  always_comb begin
    pc   = pc_q;
    epc  = epc_q;
    mode = mode_q;
    for (int unsigned t = 0; t < n_threads; t++) begin
      stalled[t] = (state_q[t] != RUN);
    end
  end

endmodule

// File: tb/tb_thread_pc.sv
// Bench for thread_pc: directed vector table, hand-written corner sequences,
// then randomized traffic checked against a per-thread behavioural model.
module tb_thread_pc;

  logic             clk;
  logic             rst;
  logic             fetch_valid;
  logic [1:0]       fetch_thread;
  logic             fetch_itlb_miss;
  logic             fetch_icache_miss;
  logic             fill_en;
  logic [1:0]       fill_thread;
  logic             br_en;
  logic [1:0]       br_thread;
  logic [31:0]      br_target;
  logic             exc_en;
  logic [1:0]       exc_thread;
  logic [31:0]      exc_pc;
  logic             iret_en;
  logic [1:0]       iret_thread;
  logic [3:0][31:0] pc;
  logic [3:0][31:0] epc;
  logic [3:0]       mode;
  logic [3:0]       stalled;

  int checks   = 0;
  int failures = 0;

  thread_pc #(
    .n_threads (4),
    .RESET_PC  (32'h0000_1000),
    .EXC_VECTOR(32'h0000_2000)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_valid      (fetch_valid),
    .fetch_thread     (fetch_thread),
    .fetch_itlb_miss  (fetch_itlb_miss),
    .fetch_icache_miss(fetch_icache_miss),
    .fill_en          (fill_en),
    .fill_thread      (fill_thread),
    .br_en            (br_en),
    .br_thread        (br_thread),
    .br_target        (br_target),
    .exc_en           (exc_en),
    .exc_thread       (exc_thread),
    .exc_pc           (exc_pc),
    .iret_en          (iret_en),
    .iret_thread      (iret_thread),
    .pc               (pc),
    .epc              (epc),
    .mode             (mode),
    .stalled          (stalled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        fv;    logic [1:0] ft;   logic itlb; logic icm;
    logic        fill;  logic [1:0] fillt;
    logic        br;    logic [1:0] brt;  logic [31:0] brtgt;
    logic        exc;   logic [1:0] exct; logic [31:0] excpc;
    logic        iret;  logic [1:0] irt;
    int          ct;
    logic [31:0] e_pc;  logic [31:0] e_epc; logic e_st; logic e_mode;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t nv(input int ct, input logic [31:0] e_pc, input logic e_st,
                              input logic e_mode, input logic [31:0] e_epc);
    vec_t v;
    v = '{fv:1'b0, ft:2'd0, itlb:1'b0, icm:1'b0, fill:1'b0, fillt:2'd0, br:1'b0, brt:2'd0,
          brtgt:32'd0, exc:1'b0, exct:2'd0, excpc:32'd0, iret:1'b0, irt:2'd0,
          ct:ct, e_pc:e_pc, e_epc:e_epc, e_st:e_st, e_mode:e_mode};
    return v;
  endfunction

  task automatic idle_inputs();
    fetch_valid = 0; fetch_thread = 0; fetch_itlb_miss = 0; fetch_icache_miss = 0;
    fill_en = 0; fill_thread = 0; br_en = 0; br_thread = 0; br_target = 0;
    exc_en = 0; exc_thread = 0; exc_pc = 0; iret_en = 0; iret_thread = 0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    fetch_valid = v.fv; fetch_thread = v.ft; fetch_itlb_miss = v.itlb; fetch_icache_miss = v.icm;
    fill_en = v.fill; fill_thread = v.fillt; br_en = v.br; br_thread = v.brt; br_target = v.brtgt;
    exc_en = v.exc; exc_thread = v.exct; exc_pc = v.excpc; iret_en = v.iret; iret_thread = v.irt;
    @(posedge clk); #1;
    chk($sformatf("vec%0d_pc%0d", idx, v.ct), pc[v.ct], v.e_pc);
    chk($sformatf("vec%0d_epc%0d", idx, v.ct), epc[v.ct], v.e_epc);
    chk($sformatf("vec%0d_stalled%0d", idx, v.ct), 32'(stalled[v.ct]), 32'(v.e_st));
    chk($sformatf("vec%0d_mode%0d", idx, v.ct), 32'(mode[v.ct]), 32'(v.e_mode));
  endtask

  task automatic chk_reset_state(input string tag);
    for (int t = 0; t < 4; t++) begin
      chk($sformatf("%s_pc%0d", tag, t), pc[t], 32'h1000);
      chk($sformatf("%s_epc%0d", tag, t), epc[t], 32'h0);
    end
    chk({tag, "_mode"}, 32'(mode), 32'hF);
    chk({tag, "_stalled"}, 32'(stalled), 32'h0);
  endtask

  // behavioural model state
  logic [31:0] m_pc [4];
  logic [31:0] m_epc[4];
  logic        m_mode[4];
  logic        m_wait[4];

  initial begin
    vec_t v;
    idle_inputs();
    rst = 1'b0;
    #12;
    chk_reset_state("reset");
    @(negedge clk);
    rst = 1'b1;

    // directed table
    v = nv(1, 32'h1004, 0, 1, 0); v.fv = 1; v.ft = 1; tbl.push_back(v);
    v = nv(1, 32'h1008, 0, 1, 0); v.fv = 1; v.ft = 1; tbl.push_back(v);
    v = nv(1, 32'h100C, 0, 1, 0); v.fv = 1; v.ft = 1; tbl.push_back(v);
    v = nv(2, 32'h1000, 1, 1, 0); v.fv = 1; v.ft = 2; v.icm = 1; tbl.push_back(v);
    v = nv(2, 32'h1000, 1, 1, 0); v.fv = 1; v.ft = 2; tbl.push_back(v);
    v = nv(2, 32'h1000, 0, 1, 0); v.fill = 1; v.fillt = 2; tbl.push_back(v);
    v = nv(2, 32'h1004, 0, 1, 0); v.fv = 1; v.ft = 2; tbl.push_back(v);
    v = nv(0, 32'h1000, 1, 1, 0); v.fv = 1; v.ft = 0; v.icm = 1; tbl.push_back(v);
    v = nv(0, 32'h3000, 1, 1, 0); v.br = 1; v.brt = 0; v.brtgt = 32'h3003; tbl.push_back(v);
    v = nv(0, 32'h3000, 1, 1, 0); v.fv = 1; v.ft = 0; tbl.push_back(v);
    v = nv(0, 32'h3000, 0, 1, 0); v.fill = 1; v.fillt = 0; tbl.push_back(v);
    v = nv(3, 32'h2000, 0, 1, 32'h1234);
    v.exc = 1; v.exct = 3; v.excpc = 32'h1234; v.br = 1; v.brt = 3; v.brtgt = 32'h5000;
    v.fv = 1; v.ft = 3; tbl.push_back(v);
    v = nv(3, 32'h1234, 0, 0, 32'h1234); v.iret = 1; v.irt = 3; tbl.push_back(v);
    v = nv(1, 32'h100C, 0, 1, 0); v.fv = 1; v.ft = 1; v.itlb = 1; v.icm = 1; tbl.push_back(v);
    v = nv(1, 32'h100C, 0, 1, 0); v.fill = 1; v.fillt = 1; tbl.push_back(v);
    v = nv(1, 32'h100C, 1, 1, 0); v.fv = 1; v.ft = 1; v.icm = 1; tbl.push_back(v);
    v = nv(1, 32'h4000, 0, 1, 0); v.fill = 1; v.fillt = 1; v.br = 1; v.brt = 1; v.brtgt = 32'h4000;
    tbl.push_back(v);
    v = nv(1, 32'h4000, 0, 1, 0); v.fill = 1; v.fillt = 1; tbl.push_back(v);
    foreach (tbl[i]) apply(tbl[i], i);

    // PC wrap at top of address space
    idle_inputs(); br_en = 1; br_thread = 1; br_target = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    chk("wrap_setup_pc1", pc[1], 32'hFFFF_FFFC);
    idle_inputs(); fetch_valid = 1; fetch_thread = 1;
    @(posedge clk); #1;
    chk("wrap_pc1", pc[1], 32'h0);

    // independent events on all four threads in one cycle
    idle_inputs();
    fetch_valid = 1; fetch_thread = 0;
    br_en = 1; br_thread = 1; br_target = 32'h10;
    fill_en = 1; fill_thread = 2;
    exc_en = 1; exc_thread = 3; exc_pc = 32'hABCD_0000;
    @(posedge clk); #1;
    chk("multi_pc0", pc[0], 32'h3004);
    chk("multi_pc1", pc[1], 32'h10);
    chk("multi_pc2", pc[2], 32'h1004);
    chk("multi_pc3", pc[3], 32'h2000);
    chk("multi_epc3", epc[3], 32'hABCD_0000);
    chk("multi_mode", 32'(mode), 32'hF);
    chk("multi_stalled", 32'(stalled), 32'h0);

    // reset asserted mid-cycle while threads 0 and 2 wait on refills
    idle_inputs(); fetch_valid = 1; fetch_thread = 0; fetch_icache_miss = 1;
    @(posedge clk); #1;
    idle_inputs(); fetch_valid = 1; fetch_thread = 2; fetch_icache_miss = 1;
    @(posedge clk); #1;
    chk("pre_rst_stalled", 32'(stalled), 32'h5);
    idle_inputs();
    #2 rst = 1'b0;
    #1;
    chk_reset_state("async_rst");
    @(negedge clk);
    rst = 1'b1;
    fill_en = 1; fill_thread = 0;
    @(posedge clk); #1;
    chk("post_rst_fill_pc0", pc[0], 32'h1000);
    chk("post_rst_fill_stalled", 32'(stalled), 32'h0);

    // randomized traffic against the model
    for (int t = 0; t < 4; t++) begin
      m_pc[t] = pc[t]; m_epc[t] = 32'h0; m_mode[t] = 1'b1; m_wait[t] = 1'b0;
    end
    chk("rand_start_pc0", m_pc[0], 32'h1000);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [31:0] n_pc[4];
      logic [31:0] n_epc[4];
      logic        n_mode[4];
      logic        n_wait[4];
      fetch_valid       = ($urandom_range(0, 1) == 0);
      fetch_thread      = 2'($urandom_range(0, 3));
      fetch_itlb_miss   = ($urandom_range(0, 9) == 0);
      fetch_icache_miss = ($urandom_range(0, 4) == 0);
      fill_en           = ($urandom_range(0, 4) == 0);
      fill_thread       = 2'($urandom_range(0, 3));
      br_en             = ($urandom_range(0, 6) == 0);
      br_thread         = 2'($urandom_range(0, 3));
      br_target         = $urandom;
      exc_en            = ($urandom_range(0, 19) == 0);
      exc_thread        = 2'($urandom_range(0, 3));
      exc_pc            = $urandom;
      iret_en           = ($urandom_range(0, 19) == 0);
      iret_thread       = 2'($urandom_range(0, 3));
      for (int t = 0; t < 4; t++) begin
        bit f, fl, b, e, ir;
        f  = fetch_valid && fetch_thread == 2'(t);
        fl = fill_en && fill_thread == 2'(t);
        b  = br_en && br_thread == 2'(t);
        e  = exc_en && exc_thread == 2'(t);
        ir = iret_en && iret_thread == 2'(t);
        n_pc[t] = m_pc[t]; n_epc[t] = m_epc[t]; n_mode[t] = m_mode[t]; n_wait[t] = m_wait[t];
        if (e) begin
          n_pc[t] = 32'h2000; n_epc[t] = exc_pc; n_mode[t] = 1'b1;
        end else if (ir) begin
          n_pc[t] = m_epc[t]; n_mode[t] = 1'b0;
        end else if (b) begin
          n_pc[t] = (br_target / 4) * 4;
        end else if (f && !m_wait[t] && !fetch_itlb_miss && !fetch_icache_miss) begin
          n_pc[t] = m_pc[t] + 4;
        end
        if (m_wait[t] && fl) n_wait[t] = 1'b0;
        else if (!m_wait[t] && f && fetch_icache_miss && !fetch_itlb_miss && !(e || ir || b))
          n_wait[t] = 1'b1;
      end
      @(posedge clk); #1;
      for (int t = 0; t < 4; t++) begin
        m_pc[t] = n_pc[t]; m_epc[t] = n_epc[t]; m_mode[t] = n_mode[t]; m_wait[t] = n_wait[t];
        chk($sformatf("rand%0d_pc%0d", cyc, t), pc[t], m_pc[t]);
        chk($sformatf("rand%0d_epc%0d", cyc, t), epc[t], m_epc[t]);
        chk($sformatf("rand%0d_mode%0d", cyc, t), 32'(mode[t]), 32'(m_mode[t]));
        chk($sformatf("rand%0d_stalled%0d", cyc, t), 32'(stalled[t]), 32'(m_wait[t]));
      end
    end

    idle_inputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/thread_pc.md
THREAD_PC -- requirements
Module: thread_pc

Interface
REQ-001 Parameter: n_threads, default 4, number of hardware threads; threadid_t width = clog2(n_threads).
REQ-002 Parameter: RESET_PC, default 32'h0000_1000, fetch address of every thread after reset.
REQ-003 Parameter: EXC_VECTOR, default 32'h0000_2000, handler entry address.
REQ-004 Port: clk  in  1  single clock, all state on rising edge.
REQ-005 Port: rst  in  1  asynchronous, active-low reset.
REQ-006 Port: fetch_valid  in  1  fetch stage issued a lookup this cycle.
REQ-007 Port: fetch_thread  in  threadid_t  thread fetched this cycle.
REQ-008 Port: fetch_itlb_miss / fetch_icache_miss  in  1 each  lookup result for fetch_thread.
REQ-009 Port: fill_en, fill_thread  in  1, threadid_t  I-cache refill completed for that thread.
REQ-010 Port: br_en, br_thread, br_target  in  1, threadid_t, vptr_t  taken-branch redirect.
REQ-011 Port: exc_en, exc_thread, exc_pc  in  1, threadid_t, vptr_t  exception, faulting PC.
REQ-012 Port: iret_en, iret_thread  in  1, threadid_t  return from handler.
REQ-013 Port: pc  out  vptr_t[n_threads]  fetch PC per thread, registered.
REQ-014 Port: epc  out  vptr_t[n_threads]  saved exception PC per thread, registered.
REQ-015 Port: mode  out  n_threads  1 = supervisor, per thread, registered.
REQ-016 Port: stalled  out  n_threads  1 = thread waiting on refill, registered (= state != RUN).

Function
REQ-017 Each thread SHALL own an independent FSM: RUN, MISS, DRAIN.
REQ-018 RUN, fetch hit (fetch_valid, fetch_thread==t, no misses): pc[t] <= pc[t]+4, modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-019 RUN, fetch_icache_miss without itlb miss: pc[t] held; state -> MISS.
REQ-020 fetch_itlb_miss: pc[t] held, state unchanged; recovery only via exc_en/br_en.
REQ-021 MISS, fill_en for t: -> RUN, pc[t] held (refetch same address next slot).
REQ-022 DRAIN, fill_en for t: -> RUN, pc[t] held (already holds redirect target).
REQ-023 fetch_valid for a thread in MISS or DRAIN SHALL be ignored (no PC change).
REQ-024 br_en for t: pc[t] <= {br_target[31:2],2'b00}; RUN stays RUN; MISS -> DRAIN; DRAIN stays DRAIN.
REQ-025 exc_en for t: pc[t] <= EXC_VECTOR, epc[t] <= exc_pc, mode[t] <= 1; FSM transitions as REQ-024.
REQ-026 iret_en for t: pc[t] <= epc[t], mode[t] <= 0; FSM transitions as REQ-024.
REQ-027 Per-thread priority, same cycle: exc_en > iret_en > br_en > fetch increment; lower ones discarded.
REQ-028 fill_en and a redirect for the same thread in MISS same cycle: state -> RUN, redirect PC applied.
REQ-029 fill_en for a thread in RUN SHALL be ignored.
REQ-030 Events targeting different threads in the same cycle SHALL all take effect independently.
REQ-031 All outputs update one cycle after the causing input edge; no combinational input-to-output path.

Reset
REQ-032 While rst==0, asynchronously: pc[*]=RESET_PC, epc[*]=0, mode[*]=1, stalled[*]=0, all FSMs RUN.
REQ-033 Reset asserted mid-MISS/DRAIN SHALL abandon the pending refill; later fill_en with thread in RUN ignored.
REQ-034 First rising edge after rst deasserts SHALL process inputs normally.

Verification
REQ-035 Reset, then 3 hits on thread 1 -> pc[1]=0x100C, other pc=0x1000, stalled=0.
REQ-036 pc[2]=0x1000, icache miss on t2 -> stalled[2]=1 next cycle; fetch_valid t2 ignored; fill_en t2 -> stalled[2]=0, pc[2]=0x1000.
REQ-037 t0 in MISS, br_en t0 target 0x3003 -> pc[0]=0x3000, DRAIN; fill_en -> RUN, pc[0]=0x3000.
REQ-038 exc_en t3 exc_pc 0x1234 with br_en t3 and hit t3 same cycle -> pc[3]=0x2000, epc[3]=0x1234, mode[3]=1; iret t3 -> pc[3]=0x1234, mode[3]=0.
REQ-039 pc[1]=0xFFFF_FFFC, hit t1 -> pc[1]=0x0000_0000.
REQ-040 rst pulsed low mid-cycle with t0 in MISS -> outputs reset immediately; subsequent fill_en t0 leaves pc[0]=0x1000, stalled[0]=0.
